idu_pipe: RTL

Pipelined, parametrised instruction-decode stage for the NPC core. It sits between the IFU and the EXU, and holds one decoded instruction in an output register behind a valid/ready handshake. It owns the GPR file (16 or 32 entries) and a per-register busy scoreboard that stalls read-after-write and write-after-write hazards until the WBU retires the producer.

---
 rtl/idu_pipe.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/idu_pipe.sv
// idu_pipe: NPC instruction-decode stage with GPR file and busy scoreboard.
// One decoded bundle is held in an output register behind valid/ready.
// out_fmt encoding: R=0 I=1 S=2 B=3 U=4 J=5, 7 = unknown opcode.
// Optional feature macro: IDU_BYPASS_EN (writeback-to-decode bypass).
module idu_pipe #(
  parameter int NR_REG = 16,
  parameter int AW     = $clog2(NR_REG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  output logic [2:0]    out_fmt,
  output logic [31:0]   out_imm,
  output logic [31:0]   out_rs1_data,
  output logic [31:0]   out_rs2_data,
  output logic [AW-1:0] out_rd,
  output logic          out_rd_wen,
  output logic          out_illegal,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          flush
);
  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5, FMT_N = 3'd7;
  localparam logic [5:0] NR_LIM = 6'(NR_REG);

  logic [6:0]    w_op;
  logic [2:0]    w_f3;
  logic [4:0]    w_rs1_f, w_rs2_f, w_rd_f;
  logic [AW-1:0] w_rs1, w_rs2, w_rd;
  logic [2:0]    w_fmt;
  logic [31:0]   w_imm;
  logic          w_rd1, w_rd2, w_wr, w_illegal, w_sys;
  logic          w_use1, w_use2, w_rd_wen;
  logic          w_byp1, w_byp2, w_bypd;
  logic          w_haz, w_slot, w_acc;
  logic [31:0]   w_rs1_data, w_rs2_data;
  logic [NR_REG-1:0] w_busy_nxt;

  logic [NR_REG-1:0] r_busy;
  logic [31:0]   r_gpr [NR_REG];
  logic          r_valid, r_rd_wen, r_illegal;
  logic [31:0]   r_pc, r_instr, r_imm, r_rs1_data, r_rs2_data;
  logic [2:0]    r_fmt;
  logic [AW-1:0] r_rd;

  assign w_op    = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_rd_f  = in_instr[11:7];
  assign w_rs1_f = in_instr[19:15];
  assign w_rs2_f = in_instr[24:20];
  assign w_rd    = in_instr[7 +: AW];
  assign w_rs1   = in_instr[15 +: AW];
  assign w_rs2   = in_instr[20 +: AW];

  // opcode -> instruction type
  always_comb begin
    w_fmt = FMT_N;
    case (w_op)
      7'b0110011:                                     w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
      7'b0100011:                                     w_fmt = FMT_S;
      7'b1100011:                                     w_fmt = FMT_B;
      7'b0110111, 7'b0010111:                         w_fmt = FMT_U;
      7'b1101111:                                     w_fmt = FMT_J;
      default:                                        w_fmt = FMT_N;
    endcase
  end

  // immediate per format; shift-immediates carry only the 5-bit shamt
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I: begin
        if (w_op == 7'b0010011 && (w_f3 == 3'b001 || w_f3 == 3'b101))
          w_imm = {27'b0, in_instr[24:20]};
        else
          w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: w_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: w_imm = {in_instr[31:12], 12'b0};
      FMT_J: w_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Field usage by format; register fields are range-checked only where the
  // format actually treats those bits as a register number.
  assign w_rd1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_rd2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
  assign w_wr  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);
  assign w_sys = (in_instr == 32'h0000_0073) || (in_instr == 32'h3020_0073);

  assign w_illegal = (w_fmt == FMT_N)
                  || (w_rd1 && ({1'b0, w_rs1_f} >= NR_LIM))
                  || (w_rd2 && ({1'b0, w_rs2_f} >= NR_LIM))
                  || (w_wr  && ({1'b0, w_rd_f}  >= NR_LIM));

  // Illegal instructions carry no dependencies and never claim rd.
  assign w_use1   = !w_illegal && w_rd1;
  assign w_use2   = !w_illegal && w_rd2;
  assign w_rd_wen = !w_illegal && w_wr && (w_rd_f != 5'd0) && !w_sys;

`ifdef IDU_BYPASS_EN
  assign w_byp1 = wb_en && (wb_addr == w_rs1) && (w_rs1 != '0);
  assign w_byp2 = wb_en && (wb_addr == w_rs2) && (w_rs2 != '0);
  assign w_bypd = wb_en && (wb_addr == w_rd);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_bypd = 1'b0;
`endif

  assign w_rs1_data = (w_rs1 == '0) ? 32'd0 : (w_byp1 ? wb_data : r_gpr[w_rs1]);
  assign w_rs2_data = (w_rs2 == '0) ? 32'd0 : (w_byp2 ? wb_data : r_gpr[w_rs2]);

  assign w_haz = (w_use1   && r_busy[w_rs1] && !w_byp1)
              || (w_use2   && r_busy[w_rs2] && !w_byp2)
              || (w_rd_wen && r_busy[w_rd]  && !w_bypd);

  assign w_slot   = !r_valid || out_ready;
  assign w_acc    = in_valid && !w_haz && !flush && w_slot;
  assign in_ready = !flush && w_slot && !(in_valid && w_haz);

  // scoreboard next state: flush/writeback clear, a new producer's set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush && r_valid && r_rd_wen) w_busy_nxt[r_rd] = 1'b0;
    if (wb_en && wb_addr != '0)       w_busy_nxt[wb_addr] = 1'b0;
    if (w_acc && w_rd_wen)            w_busy_nxt[w_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // busy scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  // GPR file; x0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REG; i++) r_gpr[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      r_gpr[wb_addr] <= wb_data;
    end
  end

  // output valid: flush beats both accept and drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_valid <= 1'b0;
    else if (flush)     r_valid <= 1'b0;
    else if (w_acc)     r_valid <= 1'b1;
    else if (out_ready) r_valid <= 1'b0;
  end

  // output bundle, loaded only on accept so it stays stable while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0; r_instr <= '0; r_fmt <= '0; r_imm <= '0;
      r_rs1_data <= '0; r_rs2_data <= '0; r_rd <= '0;
      r_rd_wen <= 1'b0; r_illegal <= 1'b0;
    end else if (w_acc) begin
      r_pc       <= in_pc;
      r_instr    <= in_instr;
      r_fmt      <= w_fmt;
      r_imm      <= w_imm;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_rd       <= w_rd;
      r_rd_wen   <= w_rd_wen;
      r_illegal  <= w_illegal;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_instr    = r_instr;
  assign out_fmt      = r_fmt;
  assign out_imm      = r_imm;
  assign out_rs1_data = r_rs1_data;
  assign out_rs2_data = r_rs2_data;
  assign out_rd       = r_rd;
  assign out_rd_wen   = r_rd_wen;
  assign out_illegal  = r_illegal;
endmodule
